// File: rtl/scroll_controller_pkg.sv
// Shared definitions for the scrolling-message sequencer: FSM state encoding,
// anode window constants and the anode decode helper.
package scroll_controller_pkg;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } scroll_state_t;

    localparam logic [3:0] AN3_ON_HI  = 4'd14;
    localparam logic [3:0] AN3_ON_LO  = 4'd13;
    localparam logic [3:0] AN2_ON_HI  = 4'd11;
    localparam logic [3:0] AN2_ON_LO  = 4'd10;
    localparam logic [3:0] AN1_ON_HI  = 4'd7;
    localparam logic [3:0] AN1_ON_LO  = 4'd6;
    localparam logic [3:0] AN0_ON_HI  = 4'd3;
    localparam logic [3:0] AN0_ON_LO  = 4'd2;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    // Counts outside every window stay blank so characters never smear across digits.
    function automatic logic [3:0] decode_an(input logic [3:0] cnt);
        logic [3:0] an_v;
        an_v = ANODES_OFF;
        if (cnt <= AN3_ON_HI && cnt >= AN3_ON_LO) begin
            an_v[3] = 1'b0;
        end else if (cnt <= AN2_ON_HI && cnt >= AN2_ON_LO) begin
            an_v[2] = 1'b0;
        end else if (cnt <= AN1_ON_HI && cnt >= AN1_ON_LO) begin
            an_v[1] = 1'b0;
        end else if (cnt <= AN0_ON_HI && cnt >= AN0_ON_LO) begin
            an_v[0] = 1'b0;
        end else begin
            an_v = ANODES_OFF;
        end
        return an_v;
    endfunction

endpackage

// File: rtl/scroll_controller_rise_edge.sv
// Rising-edge detector for a debounced button level. History resets high so a
// button held through reset does not produce a spurious edge.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q_r;

    // Previous-cycle copy of the input level.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q_r <= 1'b1;
        end else begin
            in_q_r <= in;
        end
    end

    assign rise = in & ~in_q_r;

endmodule

// File: rtl/scroll_controller.sv
// Sequencer for the 4-digit scrolling display: refresh counter, anode enables
// and message base address, stepped manually or automatically at frame boundaries.
module scroll_controller
    import scroll_controller_pkg::*;
#(
    parameter int REFRESH_DIV   = 1024,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       step_btn,
    input  logic       dir,
    output logic [3:0] anodes_counter,
    output logic [3:0] address,
    output logic [3:0] an,
    output logic       frame_end,
    output logic       auto_mode
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [PW-1:0] prescaler_r;
    logic [FW-1:0] frame_cnt_r;
    logic [FW-1:0] frame_cnt_nxt_s;
    logic          pending_r;
    logic          pending_nxt_s;
    scroll_state_t state_r;
    scroll_state_t state_nxt_s;
    logic          tick_s;
    logic          apply_s;
    logic          mode_rise_s;
    logic          step_rise_s;

    rise_edge u_mode_edge (
        .clk   (clk),
        .reset (reset),
        .in    (mode_btn),
        .rise  (mode_rise_s)
    );

    rise_edge u_step_edge (
        .clk   (clk),
        .reset (reset),
        .in    (step_btn),
        .rise  (step_rise_s)
    );

    assign tick_s    = (prescaler_r == PW'(REFRESH_DIV - 1));
    assign frame_end = tick_s && (anodes_counter == 4'd0);
    assign an        = decode_an(anodes_counter);
    assign auto_mode = (state_r == S_AUTO);

    // Refresh timing: prescaler and anode phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r    <= {PW{1'b0}};
            anodes_counter <= 4'b1111;
        end else if (tick_s) begin
            prescaler_r    <= {PW{1'b0}};
            anodes_counter <= anodes_counter - 4'd1;
        end else begin
            prescaler_r    <= prescaler_r + PW'(1);
            anodes_counter <= anodes_counter;
        end
    end

    // Mode FSM next state, pending request and frame counting; a mode toggle overrides everything.
    always_comb begin
        state_nxt_s     = state_r;
        pending_nxt_s   = pending_r;
        frame_cnt_nxt_s = frame_cnt_r;
        apply_s         = 1'b0;
        if (mode_rise_s) begin
            state_nxt_s     = (state_r == S_AUTO) ? S_MANUAL : S_AUTO;
            pending_nxt_s   = 1'b0;
            frame_cnt_nxt_s = {FW{1'b0}};
        end else begin
            case (state_r)
                S_MANUAL: begin
                    if (frame_end && pending_r) begin
                        apply_s       = 1'b1;
                        pending_nxt_s = step_rise_s;
                    end else if (step_rise_s) begin
                        pending_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = pending_r;
                    end
                end
                S_AUTO: begin
                    pending_nxt_s = 1'b0;
                    if (frame_end) begin
                        if (frame_cnt_r == FW'(SCROLL_FRAMES - 1)) begin
                            apply_s         = 1'b1;
                            frame_cnt_nxt_s = {FW{1'b0}};
                        end else begin
                            frame_cnt_nxt_s = frame_cnt_r + FW'(1);
                        end
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s     = S_MANUAL;
                    pending_nxt_s   = 1'b0;
                    frame_cnt_nxt_s = {FW{1'b0}};
                end
            endcase
        end
    end

    // FSM state, pending flag, frame counter and message address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_MANUAL;
            pending_r   <= 1'b0;
            frame_cnt_r <= {FW{1'b0}};
            address     <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            if (apply_s) begin
                address <= dir ? (address + 4'd1) : (address - 4'd1);
            end else begin
                address <= address;
            end
        end
    end

endmodule
